sarcon_scan: RTL and testbench

Multi-channel SAR conversion sequencer and next-generation SAR controller.
- Takes a start request and scans an enabled set of analog channels in ascending order.
- Per channel: drives the sample/hold phase with a programmable length, then runs an N-bit successive approximation against the external comparator.
- Presents each result with its channel tag on a valid/ready output port.
- Sits between the register/CSR front-end and the analog SAR core: capacitive DAC, S/H switch, comparator and channel mux.

---
 rtl/sarcon_pkg.sv | 49 ++++
 rtl/sar_bit_engine.sv | 47 ++++
 rtl/sarcon_scan.sv | 125 ++++++++++++
 tb/tb_sarcon_scan.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sarcon_pkg.sv
// Shared types and helpers for the SAR scan sequencer: FSM state encoding
// and the channel-mask walker used to pick the next channel to convert.
package sarcon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        STORE   = 2'd3
    } sar_state_t;

    // Widest channel mask the walker handles; the top zero-extends into this.
    localparam int MAX_CH = 32;
    localparam int MAX_CW = 5;

    typedef struct packed {
        logic              wrap;
        logic [MAX_CW-1:0] idx;
    } chan_pick_t;

    function automatic int chan_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Lowest set bit strictly above cur; if none, wrap=1 and idx is the
    // lowest set bit overall. cur = -1 yields the first channel, with
    // wrap=1 only when the mask is empty.
    function automatic chan_pick_t next_chan(input logic [MAX_CH-1:0] mask,
                                             input int cur);
        chan_pick_t pick;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > cur)) begin
                pick.idx = i[MAX_CW-1:0];
                found    = 1'b1;
            end
        end
        if (!found) begin
            pick.wrap = 1'b1;
            for (int i = MAX_CH - 1; i >= 0; i--) begin
                if (mask[i]) pick.idx = i[MAX_CW-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation register: holds the running code with the current
// trial bit set, resolves one bit per step from the comparator.
module sar_bit_engine #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         comp,
    output logic [N-1:0] dac,
    output logic         done,
    output logic         last_cycle
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  code;
    logic [IW-1:0] idx;
    logic          active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code   <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (load) begin
            code   <= {1'b1, {(N-1){1'b0}}};
            idx    <= IW'(N - 1);
            active <= 1'b1;
        end else if (step && active) begin
            // Keep or clear the trial bit, then raise the next one down.
            code[idx] <= comp;
            if (idx != '0) begin
                code[idx - IW'(1)] <= 1'b1;
                idx                <= idx - IW'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

    assign dac        = code;
    assign last_cycle = active && (idx == '0);
    assign done       = last_cycle;

endmodule

// File: rtl/sarcon_scan.sv
// Multi-channel SAR scan sequencer: walks the enabled channels in ascending
// order, runs sample + N-bit conversion per channel, emits tagged results.
module sarcon_scan
    import sarcon_pkg::*;
#(
    parameter int N   = 8,
    parameter int NCH = 4,
    parameter int CW  = chan_width(NCH),
    parameter int SW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           cont,
    input  logic [NCH-1:0] ch_mask,
    input  logic [SW-1:0]  t_samp,
    input  logic           comp,
    output logic           sample,
    output logic [CW-1:0]  ch_sel,
    output logic [N-1:0]   dac,
    output logic           busy,
    output logic [N-1:0]   res_data,
    output logic [CW-1:0]  res_ch,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           overrun,
    output logic           last_cycle
);

    // Result port: a beat transfers on a cycle where res_valid && res_ready;
    // res_data/res_ch hold steady while res_valid is high and not accepted.

    sar_state_t     state, state_nxt;
    logic [NCH-1:0] mask_q;
    logic [SW-1:0]  tsamp_q;
    logic [SW-1:0]  cnt;

    logic [N-1:0]   eng_dac;
    logic           eng_load, eng_step, eng_done, eng_last;

    chan_pick_t     first_pick, next_pick;
    logic           mask_any, start_ok, store_next, store_wrap, can_load;

    assign first_pick = next_chan(MAX_CH'(ch_mask), -1);
    assign next_pick  = next_chan(MAX_CH'(mask_q), int'(ch_sel));
    assign mask_any   = !first_pick.wrap;
    assign start_ok   = (state == IDLE) && start && mask_any;
    assign store_next = (state == STORE) && !next_pick.wrap;
    assign store_wrap = (state == STORE) && next_pick.wrap && cont && mask_any;
    assign can_load   = !res_valid || res_ready;

    sar_bit_engine #(.N(N)) u_engine (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (eng_load),
        .step       (eng_step),
        .comp       (comp),
        .dac        (eng_dac),
        .done       (eng_done),
        .last_cycle (eng_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = SAMPLE;
            SAMPLE:  if (cnt == '0) state_nxt = CONVERT;
            CONVERT: if (eng_done) state_nxt = STORE;
            STORE:   state_nxt = (store_next || store_wrap) ? SAMPLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sample     = (state == SAMPLE);
        busy       = (state != IDLE);
        eng_load   = (state == SAMPLE) && (cnt == '0);
        eng_step   = (state == CONVERT);
        last_cycle = eng_last;
        // The engine keeps its last code after a conversion; only show it
        // while converting or storing.
        dac        = ((state == CONVERT) || (state == STORE)) ? eng_dac : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            tsamp_q   <= '0;
            cnt       <= '0;
            ch_sel    <= '0;
            res_data  <= '0;
            res_ch    <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (start_ok || store_wrap) begin
                mask_q  <= ch_mask;
                tsamp_q <= t_samp;
                cnt     <= t_samp;
                ch_sel  <= CW'(first_pick.idx);
            end else if (store_next) begin
                cnt    <= tsamp_q;
                ch_sel <= CW'(next_pick.idx);
            end else if ((state == SAMPLE) && (cnt != '0)) begin
                cnt <= cnt - SW'(1);
            end

            if ((state == STORE) && can_load) begin
                res_valid <= 1'b1;
                res_data  <= eng_dac;
                res_ch    <= ch_sel;
            end else begin
                if (res_valid && res_ready) res_valid <= 1'b0;
                if (state == STORE)         overrun   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sarcon_scan.sv
// Bench for sarcon_scan: ideal comparator model, table-driven scans with a
// result scoreboard, plus hand sequences for overrun, continuous and reset.
module tb_sarcon_scan;

    localparam int N   = 8;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int SW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           cont = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic [SW-1:0]  t_samp = '0;
    logic           comp;
    logic           sample;
    logic [CW-1:0]  ch_sel;
    logic [N-1:0]   dac;
    logic           busy;
    logic [N-1:0]   res_data;
    logic [CW-1:0]  res_ch;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic           overrun;
    logic           last_cycle;

    logic [N-1:0]    ain [NCH];
    logic [CW+N-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int n_results = 0;
    int ov_cnt = 0;

    typedef struct {
        logic [NCH-1:0]   mask;
        logic [SW-1:0]    tsamp;
        logic [NCH*N-1:0] ains;
        int               exp_samp;
        int               exp_first;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    // Ideal comparator: keep the trial bit when the input is at or above it.
    assign comp = (ain[ch_sel] >= dac);

    sarcon_scan #(.N(N), .NCH(NCH), .SW(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .ch_mask    (ch_mask),
        .t_samp     (t_samp),
        .comp       (comp),
        .sample     (sample),
        .ch_sel     (ch_sel),
        .dac        (dac),
        .busy       (busy),
        .res_data   (res_data),
        .res_ch     (res_ch),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .overrun    (overrun),
        .last_cycle (last_cycle)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [CW+N-1:0] e;
        if (rst_n && overrun) ov_cnt++;
        if (rst_n && res_valid && res_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got ch %0d data %0h expected none", res_ch, res_data);
            end else begin
                e = exp_q.pop_front();
                check("res_data", res_data, e[N-1:0]);
                check("res_ch", res_ch, e[CW+N-1:N]);
            end
        end
    end

    task automatic run_scan(input logic [NCH-1:0] mask, input logic [SW-1:0] ts,
                            input int exp_samp, input int exp_first);
        int samp_cnt;
        int lat;
        bit done;
        samp_cnt = 0;
        lat = -1;
        done = 1'b0;
        for (int c = 0; c < NCH; c++)
            if (mask[c]) exp_q.push_back({CW'(c), ain[c]});
        @(posedge clk); #1;
        ch_mask = mask;
        t_samp = ts;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 600 && !done; n++) begin
            @(negedge clk);
            if (n == 0) check("first_ch_sel", ch_sel, exp_first);
            if (sample) samp_cnt++;
            if (res_valid && lat < 0) lat = n;
            if (!busy) done = 1'b1;
        end
        check("scan_done", done, 1);
        check("sample_cycles", samp_cnt, exp_samp);
        check("latency", lat, int'(ts) + N + 2);
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [N-1:0] trace [8];
        int base;
        int cnt_a;
        int cnt_b;
        int cnt_c;
        bit done;
        trace = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        for (int c = 0; c < NCH; c++) ain[c] = '0;

        vecs[0] = '{mask: 4'b1010, tsamp: 4'd3,  ains: {8'hFF, 8'h77, 8'h00, 8'h11}, exp_samp: 8,  exp_first: 1};
        vecs[1] = '{mask: 4'b1111, tsamp: 4'd1,  ains: '0, exp_samp: 8,  exp_first: 0};
        vecs[2] = '{mask: 4'b0100, tsamp: 4'd15, ains: '0, exp_samp: 16, exp_first: 2};
        vecs[3] = '{mask: 4'b1001, tsamp: 4'd2,  ains: '0, exp_samp: 6,  exp_first: 0};
        vecs[4] = '{mask: 4'b0001, tsamp: 4'd0,  ains: '0, exp_samp: 1,  exp_first: 0};
        for (int v = 1; v < 5; v++)
            for (int c = 0; c < NCH; c++)
                vecs[v].ains[c*N +: N] = N'($urandom_range(0, 255));

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_sample", sample, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_last_cycle", last_cycle, 0);
        check("rst_dac", dac, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_ch_sel", ch_sel, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single channel, 0xA5, dac trace
        ain[0] = 8'hA5;
        exp_q.push_back({CW'(0), 8'hA5});
        @(posedge clk); #1;
        ch_mask = 4'b0001;
        t_samp = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("a5_sample_on", sample, 1);
        check("a5_dac_in_sample", dac, 0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("a5_dac_trace", dac, trace[j]);
            check("a5_last_cycle", last_cycle, (j == 7) ? 1 : 0);
            if (j == 0) check("a5_sample_off", sample, 0);
        end
        @(negedge clk);
        check("a5_store_no_valid", res_valid, 0);
        check("a5_store_busy", busy, 1);
        @(negedge clk);
        check("a5_valid", res_valid, 1);
        check("a5_busy_drop", busy, 0);
        @(negedge clk);
        check("a5_valid_clear", res_valid, 0);
        check("a5_queue", exp_q.size(), 0);

        // Table-driven scans
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < NCH; c++) ain[c] = vecs[v].ains[c*N +: N];
            run_scan(vecs[v].mask, vecs[v].tsamp, vecs[v].exp_samp, vecs[v].exp_first);
        end

        // Overrun: output held, second result dropped
        ain[0] = 8'h5A;
        ain[1] = 8'hC7;
        exp_q.push_back({CW'(0), 8'h5A});
        base = ov_cnt;
        @(posedge clk); #1;
        res_ready = 1'b0;
        ch_mask = 4'b0011;
        t_samp = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (overrun) check("ov_hold_data", res_data, 8'h5A);
            if (!busy) done = 1'b1;
        end
        check("ov_scan_done", done, 1);
        repeat (3) @(negedge clk);
        check("ov_pulse_count", ov_cnt - base, 1);
        check("ov_valid_held", res_valid, 1);
        check("ov_data_held", res_data, 8'h5A);
        check("ov_ch_held", res_ch, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("ov_valid_cleared", res_valid, 0);
        check("ov_queue", exp_q.size(), 0);
        @(posedge clk); #1;
        res_ready = 1'b1;

        // Continuous mode: two scans of 0,2 then stop; start pulses ignored
        ain[0] = 8'h3C;
        ain[2] = 8'hC3;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({CW'(0), 8'h3C});
            exp_q.push_back({CW'(2), 8'hC3});
        end
        base = n_results;
        @(posedge clk); #1;
        cont = 1'b1;
        ch_mask = 4'b0101;
        t_samp = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done = 1'b0;
        for (int k = 1; k < 400 && !done; k++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
            end else begin
                if (n_results - base >= 2) cont = 1'b0;
                start = (k % 5 == 0);
            end
        end
        start = 1'b0;
        check("cont_done", done, 1);
        repeat (2) @(negedge clk);
        check("cont_result_count", n_results - base, 4);
        check("cont_queue", exp_q.size(), 0);
        cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) cnt_a++;
        end
        check("cont_idle_after", cnt_a, 0);

        // start with empty mask is ignored
        base = n_results;
        @(posedge clk); #1;
        ch_mask = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy) cnt_a++;
            if (sample) cnt_b++;
        end
        check("zero_mask_busy", cnt_a, 0);
        check("zero_mask_sample", cnt_b, 0);
        check("zero_mask_results", n_results - base, 0);

        // Asynchronous reset during bit-4 trial
        ain[0] = 8'hA5;
        @(posedge clk); #1;
        ch_mask = 4'b0001;
        t_samp = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 4; j++) @(negedge clk);
        check("ar_dac_before", dac, 8'hB0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_sample", sample, 0);
        check("ar_busy", busy, 0);
        check("ar_dac", dac, 0);
        check("ar_res_valid", res_valid, 0);
        check("ar_last_cycle", last_cycle, 0);
        check("ar_ch_sel", ch_sel, 0);
        check("ar_overrun", overrun, 0);
        #1 rst_n = 1'b1;
        base = n_results;
        cnt_a = 0;
        cnt_c = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) cnt_a++;
            if (busy) cnt_c++;
        end
        check("ar_no_valid", cnt_a, 0);
        check("ar_no_busy", cnt_c, 0);
        check("ar_no_results", n_results - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
